// File: rtl/hazard_scoreboard.sv
// Data-hazard unit: tracks in-flight register writers past ID and derives the
// ID stall, registered EX forward selects and combinational ID-compare selects.
module hazard_scoreboard #(
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned STAGES   = 3,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned PERF_W   = 32,
    localparam int unsigned SEL_W   = $clog2(STAGES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_rs,
    input  logic [ADDR_W-1:0] id_rt,
    input  logic              id_rs_rd,
    input  logic              id_rt_rd,
    input  logic              id_early,
    input  logic              id_wr_en,
    input  logic [ADDR_W-1:0] id_wr_addr,
    input  logic              id_is_load,
    input  logic              flush,
    output logic              stall,
    output logic [SEL_W-1:0]  fwd_a_ex,
    output logic [SEL_W-1:0]  fwd_b_ex,
    output logic [SEL_W-1:0]  cmp_a_sel,
    output logic [SEL_W-1:0]  cmp_b_sel,
    output logic [PERF_W-1:0] stall_cycles
);
    localparam int unsigned RP_W = $clog2(STAGES + 1);

    logic [STAGES-1:0] trk_valid;
    logic [STAGES-1:0] trk_wr;
    logic [ADDR_W-1:0] trk_addr [STAGES];
    logic [RP_W-1:0]   trk_rpos [STAGES];

    logic             ex_haz_a, ex_haz_b, id_haz_a, id_haz_b;
    logic [SEL_W-1:0] fsel_a, fsel_b, csel_a, csel_b;
    logic             load_id;

    // Search oldest-to-youngest so the lowest matching entry is the one kept.
    // WB is excluded: the register file writes through in that stage.
    always_comb begin
        ex_haz_a = 1'b0;
        id_haz_a = 1'b0;
        fsel_a   = '0;
        csel_a   = '0;
        ex_haz_b = 1'b0;
        id_haz_b = 1'b0;
        fsel_b   = '0;
        csel_b   = '0;
        for (int j = int'(STAGES) - 2; j >= 0; j--) begin
            if (trk_valid[j] && trk_wr[j] && (trk_addr[j] == id_rs) &&
                (id_rs != '0) && id_rs_rd) begin
                ex_haz_a = (j + 1) < int'(trk_rpos[j]);
                id_haz_a = j < int'(trk_rpos[j]);
                fsel_a   = SEL_W'(j + 1);
                csel_a   = SEL_W'(j);
            end
            if (trk_valid[j] && trk_wr[j] && (trk_addr[j] == id_rt) &&
                (id_rt != '0) && id_rt_rd) begin
                ex_haz_b = (j + 1) < int'(trk_rpos[j]);
                id_haz_b = j < int'(trk_rpos[j]);
                fsel_b   = SEL_W'(j + 1);
                csel_b   = SEL_W'(j);
            end
        end
    end

    assign stall     = id_valid & ~flush &
                       (ex_haz_a | ex_haz_b | (id_early & (id_haz_a | id_haz_b)));
    assign load_id   = id_valid & ~stall & ~flush;
    assign cmp_a_sel = csel_a;
    assign cmp_b_sel = csel_b;

    // Tracker shift, EX select registers and saturating stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            trk_valid <= '0;
            trk_wr    <= '0;
            for (int j = 0; j < int'(STAGES); j++) begin
                trk_addr[j] <= '0;
                trk_rpos[j] <= '0;
            end
            fwd_a_ex     <= '0;
            fwd_b_ex     <= '0;
            stall_cycles <= '0;
        end else begin
            for (int j = 1; j < int'(STAGES); j++) begin
                trk_valid[j] <= trk_valid[j-1];
                trk_wr[j]    <= trk_wr[j-1];
                trk_addr[j]  <= trk_addr[j-1];
                trk_rpos[j]  <= trk_rpos[j-1];
            end
            trk_valid[0] <= load_id;
            trk_wr[0]    <= id_wr_en;
            trk_addr[0]  <= id_wr_addr;
            trk_rpos[0]  <= id_is_load ? RP_W'(1 + LOAD_LAT) : RP_W'(1);
            fwd_a_ex     <= load_id ? fsel_a : '0;
            fwd_b_ex     <= load_id ? fsel_b : '0;
            if (stall && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + PERF_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: two configurations driven in lockstep, a per-cycle
// reference model of in-flight instructions by age, and a queue-fed monitor.
module tb_hazard_scoreboard;
    localparam int NC = 2;
    localparam int NS = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, id_valid, id_rs_rd, id_rt_rd, id_early, id_wr_en, id_is_load, flush;
    logic [4:0] id_rs, id_rt, id_wr_addr;

    logic        stall_a, stall_b;
    logic [1:0]  fa_a, fb_a, ca_a, cb_a, fa_b, fb_b, ca_b, cb_b;
    logic [31:0] sc_a;
    logic [3:0]  sc_b;

    hazard_scoreboard #(.ADDR_W(5), .STAGES(3), .LOAD_LAT(1), .PERF_W(32)) u_a (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_rd(id_rs_rd), .id_rt_rd(id_rt_rd), .id_early(id_early),
        .id_wr_en(id_wr_en), .id_wr_addr(id_wr_addr), .id_is_load(id_is_load),
        .flush(flush), .stall(stall_a), .fwd_a_ex(fa_a), .fwd_b_ex(fb_a),
        .cmp_a_sel(ca_a), .cmp_b_sel(cb_a), .stall_cycles(sc_a));

    hazard_scoreboard #(.ADDR_W(5), .STAGES(4), .LOAD_LAT(2), .PERF_W(4)) u_b (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_rd(id_rs_rd), .id_rt_rd(id_rt_rd), .id_early(id_early),
        .id_wr_en(id_wr_en), .id_wr_addr(id_wr_addr), .id_is_load(id_is_load),
        .flush(flush), .stall(stall_b), .fwd_a_ex(fa_b), .fwd_b_ex(fb_b),
        .cmp_a_sel(ca_b), .cmp_b_sel(cb_b), .stall_cycles(sc_b));

    typedef struct {
        int     c;
        bit     stall;
        int     fa, fb, ca, cb;
        longint sc;
    } want_t;
    want_t sbq[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a set of in-flight writers, each with its age in cycles past ID.
    bit     live [NC][NS];
    int     age  [NC][NS];
    int     dst  [NC][NS];
    bit     ldf  [NC][NS];
    int     m_fa [NC];
    int     m_fb [NC];
    longint m_sc [NC];
    bit     p_issue [NC];
    bit     p_stall [NC];
    int     p_nfa [NC];
    int     p_nfb [NC];
    bit     p_rst = 1'b1;
    bit     p_wr  = 1'b0;
    bit     p_ld  = 1'b0;
    int     p_wa  = 0;

    function automatic int stg(input int c);   return (c == 0) ? 3 : 4; endfunction
    function automatic int lat(input int c);   return (c == 0) ? 1 : 2; endfunction
    function automatic longint scmax(input int c);
        return (c == 0) ? 64'h0000_0000_FFFF_FFFF : 64'd15;
    endfunction

    task automatic chk(input string nm, input longint act, input longint want);
        n_tests++;
        if (act != want) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, want);
        end
    endtask

    // Youngest writer of src still before WB; rdy is the age from which its result exists.
    function automatic void lookup(input int c, input int src, input bit rd,
                                   output bit hit, output int a, output int rdy);
        hit = 1'b0; a = 0; rdy = 0;
        for (int s = 0; s < NS; s++) begin
            if (live[c][s] && rd && src != 0 && dst[c][s] == src &&
                age[c][s] <= stg(c) - 2 && (!hit || age[c][s] < a)) begin
                hit = 1'b1;
                a   = age[c][s];
                rdy = ldf[c][s] ? 1 + lat(c) : 1;
            end
        end
    endfunction

    task automatic advance(input int c);
        if (p_rst) begin
            for (int s = 0; s < NS; s++) live[c][s] = 1'b0;
            m_fa[c] = 0; m_fb[c] = 0; m_sc[c] = 0;
        end else begin
            for (int s = 0; s < NS; s++) begin
                if (live[c][s]) begin
                    age[c][s]++;
                    if (age[c][s] >= stg(c)) live[c][s] = 1'b0;
                end
            end
            if (p_issue[c] && p_wr) begin
                for (int s = 0; s < NS; s++) begin
                    if (!live[c][s]) begin
                        live[c][s] = 1'b1; age[c][s] = 0; dst[c][s] = p_wa; ldf[c][s] = p_ld;
                        break;
                    end
                end
            end
            m_fa[c] = p_issue[c] ? p_nfa[c] : 0;
            m_fb[c] = p_issue[c] ? p_nfb[c] : 0;
            if (p_stall[c] && m_sc[c] < scmax(c)) m_sc[c]++;
        end
    endtask

    task automatic predict(input int c);
        bit ha, hb, st;
        int aa, ab, ra, rb;
        want_t w;
        lookup(c, int'(id_rs), id_rs_rd, ha, aa, ra);
        lookup(c, int'(id_rt), id_rt_rd, hb, ab, rb);
        st = id_valid && !flush &&
             ((ha && aa + 1 < ra) || (hb && ab + 1 < rb) ||
              (id_early && ((ha && aa < ra) || (hb && ab < rb))));
        p_stall[c] = st;
        p_issue[c] = id_valid && !st && !flush;
        p_nfa[c]   = ha ? aa + 1 : 0;
        p_nfb[c]   = hb ? ab + 1 : 0;
        w.c = c; w.stall = st; w.fa = m_fa[c]; w.fb = m_fb[c];
        w.ca = ha ? aa : 0; w.cb = hb ? ab : 0; w.sc = m_sc[c];
        sbq.push_back(w);
    endtask

    task automatic step(input bit v, input int rs, input int rt, input bit ra, input bit rb,
                        input bit e, input bit w, input int wa, input bit ld,
                        input bit fl, input bit r);
        @(posedge clk);
        #1;
        for (int c = 0; c < NC; c++) advance(c);
        rst = r; id_valid = v; id_rs = 5'(rs); id_rt = 5'(rt); id_rs_rd = ra; id_rt_rd = rb;
        id_early = e; id_wr_en = w; id_wr_addr = 5'(wa); id_is_load = ld; flush = fl;
        p_rst = r; p_wr = w; p_wa = wa; p_ld = ld;
        for (int c = 0; c < NC; c++) predict(c);
    endtask

    task automatic nop();                         step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic do_rst();                      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); endtask
    task automatic alu(input int d, input int s, input int t); step(1, s, t, 1, 1, 0, 1, d, 0, 0, 0); endtask
    task automatic lw(input int d);               step(1, 1, 0, 1, 0, 0, 1, d, 1, 0, 0); endtask
    task automatic beq(input int s, input int t); step(1, s, t, 1, 1, 1, 0, 0, 0, 0, 0); endtask

    // Monitor: every cycle the DUT outputs are compared against the queued predictions.
    always @(negedge clk) begin
        while (sbq.size() > 0) begin
            want_t w;
            w = sbq.pop_front();
            if (w.c == 0) begin
                chk("sb_A_stall", longint'(stall_a), longint'(w.stall));
                chk("sb_A_fwd_a", longint'(fa_a), w.fa);
                chk("sb_A_fwd_b", longint'(fb_a), w.fb);
                chk("sb_A_cmp_a", longint'(ca_a), w.ca);
                chk("sb_A_cmp_b", longint'(cb_a), w.cb);
                chk("sb_A_cycles", longint'(sc_a), w.sc);
            end else begin
                chk("sb_B_stall", longint'(stall_b), longint'(w.stall));
                chk("sb_B_fwd_a", longint'(fa_b), w.fa);
                chk("sb_B_fwd_b", longint'(fb_b), w.fb);
                chk("sb_B_cmp_a", longint'(ca_b), w.ca);
                chk("sb_B_cmp_b", longint'(cb_b), w.cb);
                chk("sb_B_cycles", longint'(sc_b), w.sc);
            end
        end
    end

    initial begin
        rst = 1'b1; id_valid = 1'b0; id_rs = '0; id_rt = '0; id_rs_rd = 1'b0; id_rt_rd = 1'b0;
        id_early = 1'b0; id_wr_en = 1'b0; id_wr_addr = '0; id_is_load = 1'b0; flush = 1'b0;

        do_rst(); nop(); #1;
        chk("reset_stall_A", longint'(stall_a), 0);
        chk("reset_fwd_A", longint'(fa_a), 0);
        chk("reset_cycles_B", longint'(sc_b), 0);

        // ALU producer followed by consumer: forwarded from stage 1, no stall
        alu(3, 1, 2); alu(4, 3, 1); #1;
        chk("t1_stall_A", longint'(stall_a), 0);
        chk("t1_stall_B", longint'(stall_b), 0);
        nop(); #1;
        chk("t1_fwd_a_A", longint'(fa_a), 1);
        chk("t1_fwd_b_A", longint'(fb_a), 0);

        // load-use with one extra cycle of load latency
        do_rst(); lw(5); alu(6, 5, 5); #1;
        chk("t2_stall1_A", longint'(stall_a), 1);
        alu(6, 5, 5); #1;
        chk("t2_stall2_A", longint'(stall_a), 0);
        nop(); #1;
        chk("t2_fwd_a_A", longint'(fa_a), 2);
        chk("t2_fwd_b_A", longint'(fb_a), 2);
        chk("t2_cycles_A", longint'(sc_a), 1);

        // deeper pipe with two extra cycles of load latency
        do_rst(); lw(2); step(1, 2, 0, 1, 0, 0, 1, 9, 0, 0, 0); #1;
        chk("t3_stall1_B", longint'(stall_b), 1);
        step(1, 2, 0, 1, 0, 0, 1, 9, 0, 0, 0); #1;
        chk("t3_stall2_B", longint'(stall_b), 1);
        step(1, 2, 0, 1, 0, 0, 1, 9, 0, 0, 0); #1;
        chk("t3_stall3_B", longint'(stall_b), 0);
        nop(); #1;
        chk("t3_fwd_a_B", longint'(fa_b), 3);
        chk("t3_cycles_B", longint'(sc_b), 2);

        // branch compare in ID needs the ALU result one stage later
        do_rst(); alu(4, 1, 2); beq(4, 0); #1;
        chk("t4_stall1_A", longint'(stall_a), 1);
        beq(4, 0); #1;
        chk("t4_stall2_A", longint'(stall_a), 0);
        chk("t4_cmp_a_A", longint'(ca_a), 1);
        chk("t4_cmp_b_A", longint'(cb_a), 0);

        // two writers of r7: the youngest supplies the operand
        do_rst(); alu(7, 1, 2); alu(7, 2, 3); alu(8, 7, 0); #1;
        chk("t5_stall_A", longint'(stall_a), 0);
        nop(); #1;
        chk("t5_fwd_a_A", longint'(fa_a), 1);
        do_rst(); alu(0, 1, 2); alu(0, 2, 3); beq(0, 0); #1;
        chk("t5_r0_stall_A", longint'(stall_a), 0);
        chk("t5_r0_cmp_a_A", longint'(ca_a), 0);
        nop(); #1;
        chk("t5_r0_fwd_a_A", longint'(fa_a), 0);

        // flush during a load-use stall, then reset during a load-use stall
        do_rst(); lw(5); step(1, 5, 0, 1, 0, 0, 1, 6, 0, 1, 0); #1;
        chk("t6_flush_stall_A", longint'(stall_a), 0);
        nop(); #1;
        chk("t6_flush_fwd_A", longint'(fa_a), 0);
        chk("t6_flush_cycles_A", longint'(sc_a), 0);
        do_rst(); lw(5); step(1, 5, 5, 1, 1, 1, 1, 6, 0, 0, 1); #1;
        chk("t6_rst_stall_before_A", longint'(stall_a), 1);
        step(1, 5, 5, 1, 1, 1, 1, 6, 0, 0, 0); #1;
        chk("t6_rst_stall_A", longint'(stall_a), 0);
        chk("t6_rst_fwd_A", longint'(fa_a), 0);
        chk("t6_rst_cmp_A", longint'(ca_a), 0);
        chk("t6_rst_cycles_A", longint'(sc_a), 0);

        // random traffic on a small register set to provoke frequent hazards
        for (int i = 0; i < 3000; i++) begin
            step($urandom % 4 != 0, int'($urandom % 6), int'($urandom % 6),
                 $urandom % 4 != 0, $urandom % 2 == 0, $urandom % 4 == 0,
                 $urandom % 4 != 0, int'($urandom % 6), $urandom % 3 == 0,
                 $urandom % 16 == 0, $urandom % 400 == 0);
        end
        nop(); nop();
        @(negedge clk); #1;
        chk("queue_drained", longint'(sbq.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
